// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver types and scan-code constants.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus deglitch filter for one PS/2 line.
// The filtered level flips only after FILTER_LEN consecutive opposite
// samples; 'fall' is a one-cycle strobe on a filtered 1->0 transition.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic level,
  output logic fall
);

  localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          fall_q, fall_d;

  // Next-state: shift the synchronizer, count opposite samples, flip on a full run.
  always_comb begin
    sync_d  = {sync_q[0], raw_in};
    level_d = level_q;
    cnt_d   = '0;
    fall_d  = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        level_d = sync_q[1];
        fall_d  = level_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Registers; the idle (released) bus level is 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign fall  = fall_q;

endmodule

// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard receiver: frames start/8 data/odd parity/stop, strips F0
// (break) and E0 (extended) prefixes and holds the last make code on KeyOut.
// Optional macro PS2_TIMEOUT_EN adds a partial-frame watchdog.
module ps2_scancode_receiver
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PS2Clk,
  input  logic       PS2Data,
  output logic [7:0] KeyOut,
  output logic       KeyExt,
  output logic       KeyValid,
  output logic       ParityErr
);

  logic clk_fall;
  logic data_lvl;
  logic unused_clk_lvl;
  logic unused_data_fall;
  logic timeout_c;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk    (CLK),
    .rst    (RST),
    .raw_in (PS2Clk),
    .level  (unused_clk_lvl),
    .fall   (clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk    (CLK),
    .rst    (RST),
    .raw_in (PS2Data),
    .level  (data_lvl),
    .fall   (unused_data_fall)
  );

  ps2_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic       par_q, par_d;
  logic       brk_q, brk_d;
  logic       ext_q, ext_d;
  logic [7:0] key_q, key_d;
  logic       key_ext_q, key_ext_d;
  logic       valid_q, valid_d;
  logic       perr_q, perr_d;

`ifdef PS2_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] to_cnt_q, to_cnt_d;

  // Watchdog: reload on every strobe, count only inside a frame.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (clk_fall || (state_q == ST_IDLE)) begin
      to_cnt_d = '0;
    end else if (!timeout_c) begin
      to_cnt_d = to_cnt_q + TW'(1);
    end
  end

  // Watchdog counter register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  assign timeout_c = (state_q != ST_IDLE) && (to_cnt_q == TW'(TIMEOUT_CYCLES));
`else
  logic unused_timeout_c;

  assign timeout_c        = 1'b0;
  assign unused_timeout_c = (TIMEOUT_CYCLES == 0);
`endif

  // Frame FSM and scan-code decode; everything advances on the clock strobe.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    brk_d     = brk_q;
    ext_d     = ext_q;
    key_d     = key_q;
    key_ext_d = key_ext_q;
    valid_d   = 1'b0;
    perr_d    = 1'b0;

    if (timeout_c) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      brk_d   = 1'b0;
      ext_d   = 1'b0;
    end else if (clk_fall) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!data_lvl) begin
            state_d = ST_DATA;
            cnt_d   = '0;
          end
        end
        ST_DATA: begin
          shreg_d = {data_lvl, shreg_q[7:1]};
          if (cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        ST_PARITY: begin
          par_d   = data_lvl;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          if ((^{shreg_q, par_q}) && data_lvl) begin
            if (shreg_q == PS2_BREAK) begin
              brk_d = 1'b1;
            end else if (shreg_q == PS2_EXT) begin
              ext_d = 1'b1;
            end else if (brk_q) begin
              brk_d = 1'b0;
              ext_d = 1'b0;
            end else begin
              key_d     = shreg_q;
              key_ext_d = ext_q;
              valid_d   = 1'b1;
              ext_d     = 1'b0;
            end
          end else begin
            perr_d = 1'b1;
            brk_d  = 1'b0;
            ext_d  = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and registered outputs; reset wins over a coincident strobe.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      brk_q     <= 1'b0;
      ext_q     <= 1'b0;
      key_q     <= 8'h00;
      key_ext_q <= 1'b0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      brk_q     <= brk_d;
      ext_q     <= ext_d;
      key_q     <= key_d;
      key_ext_q <= key_ext_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
    end
  end

  assign KeyOut    = key_q;
  assign KeyExt    = key_ext_q;
  assign KeyValid  = valid_q;
  assign ParityErr = perr_q;

endmodule
